frame_deserializer: RTL and testbench
=====================================

// Module: frame_deserializer
// PURPOSE
//  Consumer of the bit clock recovery stage. Takes the raw serial `signal` and the recovered bit period
//  (clk_freq, in clk_300M cycles), samples each bit at mid-period, hunts for a sync word, then emits
//  framed bytes MSB-first. Lock is held across a bounded number of bad sync words (flywheel).
// PARAMETERS
//  PERIOD_W     32        width of bit_period and phase counter
//  SYNC_W       16        sync word length, bits
//  SYNC_WORD    16'hEB90  frame sync pattern, MSB received first
//  FRAME_BYTES  8         payload bytes per frame (1..255)
//  MAX_MISS     3         consecutive sync misses before lock is dropped (1..15)
// PORTS
//  clk_300M     in   1         base clock, all logic on posedge
//  rst          in   1         synchronous, active-high reset
//  signal       in   1         raw serial input, asynchronous
//  bit_period   in   PERIOD_W  recovered bit period in clk_300M cycles (clk_freq from recovery stage)
//  bit_strobe   out  1         one-cycle pulse per sampled bit
//  bit_data     out  1         sampled bit value, valid with bit_strobe
//  data_byte    out  8         assembled payload byte
//  data_valid   out  1         one-cycle pulse, data_byte valid
//  frame_start  out  1         one-cycle pulse on each accepted sync word
//  locked       out  1         high from first sync match until MAX_MISS consecutive misses
//  polarity_inv out  1         only with SYNC_INVERT_EN; high when inverted sync detected
// BEHAVIOUR
//  Reset: all outputs 0, state HUNT, phase/bit/byte/miss counters 0, sync window 0; partial byte discarded.
//  Input: signal through 2-flop synchronizer, then edge detect (3 cycles edge-to-detect latency).
//  Phase: phase_cnt resets to 0 on detected edge; else increments; wraps to 0 when phase_cnt >= bit_period-1.
//  Sample: bit_strobe when phase_cnt == bit_period>>1 and no edge this cycle (edge wins on coincidence).
//  bit_period < 4: no sampling, no strobes; FSM holds state. bit_period change takes effect immediately.
//  FSM (one sample per step):
//   HUNT : shift bit into SYNC_W window; window==SYNC_WORD -> DATA, frame_start, locked<=1, miss_cnt<=0.
//   DATA : shift bits into byte reg; on 8th bit, data_byte/data_valid the cycle after the strobe;
//          after FRAME_BYTES bytes -> CHECK, bit counter 0.
//   CHECK: collect SYNC_W bits; match -> DATA, frame_start, miss_cnt<=0;
//          miss -> miss_cnt+1; if miss_cnt+1==MAX_MISS -> HUNT, locked<=0, window cleared; else -> DATA
//          (flywheel, no frame_start).
//  data_valid and frame_start never asserted in the same cycle; data_valid never asserted in HUNT.
//  Counters saturate: phase_cnt at all-ones; byte counter width $clog2(FRAME_BYTES+1).
// CONFIGURATION
//  SYNC_INVERT_EN defined: HUNT also matches ~SYNC_WORD; on that match polarity_inv<=1 and every
//   subsequent sampled bit (bit_data, bytes, CHECK window) is inverted until return to HUNT (clears it).
//  SYNC_INVERT_EN undefined: only SYNC_WORD matches; polarity_inv port absent.
// STRUCTURE
//  Package bitrec_pkg: state enum {HUNT, DATA, CHECK}, SYNC_WORD default, MIN_PERIOD=4.
//  Sub-module bit_sampler: synchronizer, edge detect, phase counter, bit_strobe/bit_data generation.
//  Top: FSM, sync window, byte assembly, miss counter.
// TESTING
//  1 bit_period=100, send SYNC_WORD + bytes 01..08 -> frame_start once, 8 data_valid with 01..08, locked=1.
//  2 Two frames back to back, second sync intact -> second frame_start, 16 bytes total, miss_cnt stays 0.
//  3 Locked, corrupt next 3 sync words (MAX_MISS=3) -> bytes keep flowing after misses 1,2; locked=0 after 3rd.
//  4 bit_period=3, toggle signal -> no bit_strobe, no data_valid; raise to 100 -> sampling resumes.
//  5 Assert rst mid-byte 5 -> next cycle all outputs 0, HUNT; resend frame -> clean relock, bytes 01..08.
//  6 SYNC_INVERT_EN, send ~SYNC_WORD + inverted bytes -> polarity_inv=1, data_byte 01..08 uncorrupted.

Source files
------------

// File: rtl/bitrec_pkg.sv
// Shared types and constants for the frame deserializer and its bit sampler.
package bitrec_pkg;

  typedef enum logic [1:0] {HUNT, DATA, CHECK} state_t;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;
  localparam int          MIN_PERIOD    = 4;

endpackage

// File: rtl/bit_sampler.sv
// Synchronizes the raw serial input, tracks bit phase from its edges and
// emits one registered strobe per bit, sampled at mid-period.
module bit_sampler
  import bitrec_pkg::*;
#(
  parameter int PERIOD_W = 32
) (
  input  logic                clk_300M,
  input  logic                rst,
  input  logic                signal,
  input  logic [PERIOD_W-1:0] bit_period,
  output logic                bit_strobe,
  output logic                bit_data
);

  logic [2:0]          sync_q;
  logic                edge_det;
  logic                period_ok;
  logic                sample;
  logic [PERIOD_W-1:0] phase_cnt;

  assign edge_det  = sync_q[1] ^ sync_q[2];
  assign period_ok = bit_period >= PERIOD_W'(MIN_PERIOD);
  // An edge on the sample cycle means the bit boundary moved; skip that sample.
  assign sample    = period_ok && !edge_det && (phase_cnt == (bit_period >> 1));

  always_ff @(posedge clk_300M) begin
    if (rst) begin
      sync_q     <= '0;
      phase_cnt  <= '0;
      bit_strobe <= 1'b0;
      bit_data   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], signal};
      bit_strobe <= sample;
      bit_data   <= sync_q[1];
      if (edge_det)
        phase_cnt <= '0;
      else if (phase_cnt >= bit_period - 1'b1)
        phase_cnt <= '0;
      else if (phase_cnt != '1)
        phase_cnt <= phase_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/frame_deserializer.sv
// Sync-word hunt, byte assembly and flywheel lock on top of bit_sampler.
// Optional SYNC_INVERT_EN: also lock on the inverted sync word and invert all following bits.
module frame_deserializer
  import bitrec_pkg::*;
#(
  parameter int              PERIOD_W    = 32,
  parameter int              SYNC_W      = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int              FRAME_BYTES = 8,
  parameter int              MAX_MISS    = 3
) (
  input  logic                clk_300M,
  input  logic                rst,
  input  logic                signal,
  input  logic [PERIOD_W-1:0] bit_period,
  output logic                bit_strobe,
  output logic                bit_data,
  output logic [7:0]          data_byte,
  output logic                data_valid,
  output logic                frame_start,
`ifdef SYNC_INVERT_EN
  output logic                polarity_inv,
`endif
  output logic                locked
);

  localparam int BC_W = ($clog2(SYNC_W) > 3) ? $clog2(SYNC_W) : 3;
  localparam int BY_W = $clog2(FRAME_BYTES + 1);

  state_t            state, state_nx;
  logic [SYNC_W-1:0] window, window_nx, win_sh;
  logic [7:0]        byte_sr, byte_sr_nx, byte_sh, data_byte_nx;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_nx;
  logic [BY_W-1:0]   byte_cnt, byte_cnt_nx, byte_inc;
  logic [3:0]        miss_cnt, miss_nx, miss_inc;
  logic              locked_nx, dv_nx, fs_nx;
  logic              bit_val;

  bit_sampler #(.PERIOD_W(PERIOD_W)) u_sampler (
    .clk_300M   (clk_300M),
    .rst        (rst),
    .signal     (signal),
    .bit_period (bit_period),
    .bit_strobe (bit_strobe),
    .bit_data   (bit_data)
  );

`ifdef SYNC_INVERT_EN
  logic pol, pol_nx;
  assign bit_val      = bit_data ^ pol;
  assign polarity_inv = pol;
`else
  assign bit_val = bit_data;
`endif

  assign win_sh   = {window[SYNC_W-2:0], bit_val};
  assign byte_sh  = {byte_sr[6:0], bit_val};
  assign byte_inc = (byte_cnt == '1) ? byte_cnt : byte_cnt + 1'b1;
  assign miss_inc = miss_cnt + 4'd1;

  always_comb begin
    state_nx     = state;
    window_nx    = window;
    byte_sr_nx   = byte_sr;
    bit_cnt_nx   = bit_cnt;
    byte_cnt_nx  = byte_cnt;
    miss_nx      = miss_cnt;
    locked_nx    = locked;
    data_byte_nx = data_byte;
    dv_nx        = 1'b0;
    fs_nx        = 1'b0;
`ifdef SYNC_INVERT_EN
    pol_nx       = pol;
`endif
    if (bit_strobe) begin
      unique case (state)
        HUNT: begin
          window_nx = win_sh;
          if (win_sh == SYNC_WORD) begin
            state_nx    = DATA;
            fs_nx       = 1'b1;
            locked_nx   = 1'b1;
            miss_nx     = '0;
            bit_cnt_nx  = '0;
            byte_cnt_nx = '0;
          end
`ifdef SYNC_INVERT_EN
          else if (win_sh == ~SYNC_WORD) begin
            state_nx    = DATA;
            fs_nx       = 1'b1;
            locked_nx   = 1'b1;
            miss_nx     = '0;
            bit_cnt_nx  = '0;
            byte_cnt_nx = '0;
            pol_nx      = 1'b1;
          end
`endif
        end
        DATA: begin
          byte_sr_nx = byte_sh;
          if (bit_cnt == BC_W'(7)) begin
            bit_cnt_nx   = '0;
            data_byte_nx = byte_sh;
            dv_nx        = 1'b1;
            if (byte_inc == BY_W'(FRAME_BYTES)) begin
              state_nx    = CHECK;
              byte_cnt_nx = '0;
            end else begin
              byte_cnt_nx = byte_inc;
            end
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end
        CHECK: begin
          window_nx = win_sh;
          if (bit_cnt == BC_W'(SYNC_W - 1)) begin
            bit_cnt_nx = '0;
            if (win_sh == SYNC_WORD) begin
              state_nx = DATA;
              fs_nx    = 1'b1;
              miss_nx  = '0;
            end else if (miss_inc == 4'(MAX_MISS)) begin
              state_nx  = HUNT;
              locked_nx = 1'b0;
              window_nx = '0;
              miss_nx   = miss_inc;
`ifdef SYNC_INVERT_EN
              pol_nx    = 1'b0;
`endif
            end else begin
              // Flywheel: trust the frame timing and keep collecting payload.
              state_nx = DATA;
              miss_nx  = miss_inc;
            end
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_300M) begin
    if (rst) state <= HUNT;
    else     state <= state_nx;
  end

  always_ff @(posedge clk_300M) begin
    if (rst) begin
      window      <= '0;
      byte_sr     <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      miss_cnt    <= '0;
      locked      <= 1'b0;
      data_byte   <= '0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
`ifdef SYNC_INVERT_EN
      pol         <= 1'b0;
`endif
    end else begin
      window      <= window_nx;
      byte_sr     <= byte_sr_nx;
      bit_cnt     <= bit_cnt_nx;
      byte_cnt    <= byte_cnt_nx;
      miss_cnt    <= miss_nx;
      locked      <= locked_nx;
      data_byte   <= data_byte_nx;
      data_valid  <= dv_nx;
      frame_start <= fs_nx;
`ifdef SYNC_INVERT_EN
      pol         <= pol_nx;
`endif
    end
  end

endmodule

// File: tb/tb_frame_deserializer.sv
// Directed bench for frame_deserializer: lock, back-to-back frames, flywheel,
// short-period inhibit, mid-frame reset and (with SYNC_INVERT_EN) inverted sync.
module tb_frame_deserializer;
  import bitrec_pkg::*;

  localparam int TB_PER = 100;

  logic        clk_300M = 1'b0;
  logic        rst = 1'b1;
  logic        signal = 1'b0;
  logic [31:0] bit_period = 32'd100;
  logic        bit_strobe, bit_data, data_valid, frame_start, locked;
  logic [7:0]  data_byte;
`ifdef SYNC_INVERT_EN
  logic        polarity_inv;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int n_fs = 0;
  int n_stb = 0;
  logic [7:0] bytes_q[$];

  frame_deserializer dut (
    .clk_300M    (clk_300M),
    .rst         (rst),
    .signal      (signal),
    .bit_period  (bit_period),
    .bit_strobe  (bit_strobe),
    .bit_data    (bit_data),
    .data_byte   (data_byte),
    .data_valid  (data_valid),
    .frame_start (frame_start),
`ifdef SYNC_INVERT_EN
    .polarity_inv(polarity_inv),
`endif
    .locked      (locked)
  );

  always #5 clk_300M = ~clk_300M;

  always @(negedge clk_300M) begin
    if (data_valid)  bytes_q.push_back(data_byte);
    if (frame_start) n_fs++;
    if (bit_strobe)  n_stb++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    signal = b;
    repeat (TB_PER) @(posedge clk_300M);
  endtask

  task automatic send_word16(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_frame(input logic [15:0] sw, input logic [7:0] first, input logic inv);
    send_word16(sw);
    for (int k = 0; k < 8; k++) send_byte((first + 8'(k)) ^ {8{inv}});
  endtask

  task automatic check_bytes(input string tag, input int base, input logic [7:0] first);
    logic [31:0] obs;
    for (int k = 0; k < 8; k++) begin
      obs = 'x;
      if (base + k < bytes_q.size()) obs = {24'd0, bytes_q[base + k]};
      chk($sformatf("%s_byte%0d", tag, k), obs, {24'd0, first + 8'(k)});
    end
  endtask

  initial begin
    int s0, d0, f0, base;

    repeat (5) @(posedge clk_300M);
    @(negedge clk_300M);
    chk("rst_strobe", {31'd0, bit_strobe}, 32'd0);
    chk("rst_dv", {31'd0, data_valid}, 32'd0);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_byte", {24'd0, data_byte}, 32'd0);
    rst = 1'b0;
    repeat (4) send_bit(1'b0);

    // 1: single frame
    send_frame(16'hEB90, 8'h01, 1'b0);
    @(negedge clk_300M);
    chk("t1_fs", n_fs, 1);
    chk("t1_count", bytes_q.size(), 8);
    check_bytes("t1", 0, 8'h01);
    chk("t1_locked", {31'd0, locked}, 32'd1);

    // 2: back-to-back frame with intact sync
    send_frame(16'hEB90, 8'h11, 1'b0);
    @(negedge clk_300M);
    chk("t2_fs", n_fs, 2);
    chk("t2_count", bytes_q.size(), 16);
    check_bytes("t2", 8, 8'h11);
    chk("t2_miss", {28'd0, dut.miss_cnt}, 32'd0);

    // 3: three corrupted sync words
    send_frame(16'hEB91, 8'h21, 1'b0);
    @(negedge clk_300M);
    chk("t3_m1_fs", n_fs, 2);
    chk("t3_m1_count", bytes_q.size(), 24);
    check_bytes("t3_m1", 16, 8'h21);
    chk("t3_m1_locked", {31'd0, locked}, 32'd1);
    send_frame(16'h6B90, 8'h31, 1'b0);
    @(negedge clk_300M);
    chk("t3_m2_count", bytes_q.size(), 32);
    check_bytes("t3_m2", 24, 8'h31);
    chk("t3_m2_locked", {31'd0, locked}, 32'd1);
    send_word16(16'hEB80);
    @(negedge clk_300M);
    chk("t3_m3_locked", {31'd0, locked}, 32'd0);
    chk("t3_m3_fs", n_fs, 2);
    chk("t3_m3_state", 32'(dut.state), 32'(HUNT));

    // 4: bit_period below minimum inhibits sampling
    bit_period = 32'd3;
    repeat (3) @(posedge clk_300M);
    @(negedge clk_300M);
    s0 = n_stb;
    d0 = bytes_q.size();
    for (int i = 0; i < 20; i++) begin
      signal = ~signal;
      repeat (5) @(posedge clk_300M);
    end
    @(negedge clk_300M);
    chk("t4_no_strobe", n_stb, s0);
    chk("t4_no_dv", bytes_q.size(), d0);
    bit_period = 32'd100;
    s0 = n_stb;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    @(negedge clk_300M);
    chk("t4_resume", n_stb, s0 + 4);

    // 5: reset in the middle of byte 5, then relock
    base = bytes_q.size();
    f0 = n_fs;
    send_word16(16'hEB90);
    for (int k = 1; k <= 4; k++) send_byte(8'(k));
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(negedge clk_300M);
    rst = 1'b1;
    @(negedge clk_300M);
    chk("t5_pre_count", bytes_q.size(), base + 4);
    chk("t5_rst_strobe", {31'd0, bit_strobe}, 32'd0);
    chk("t5_rst_bit", {31'd0, bit_data}, 32'd0);
    chk("t5_rst_byte", {24'd0, data_byte}, 32'd0);
    chk("t5_rst_dv", {31'd0, data_valid}, 32'd0);
    chk("t5_rst_fs", {31'd0, frame_start}, 32'd0);
    chk("t5_rst_locked", {31'd0, locked}, 32'd0);
    chk("t5_rst_state", 32'(dut.state), 32'(HUNT));
    rst = 1'b0;
    base = bytes_q.size();
    send_frame(16'hEB90, 8'h01, 1'b0);
    @(negedge clk_300M);
    chk("t5_fs", n_fs, f0 + 2);
    chk("t5_count", bytes_q.size(), base + 8);
    check_bytes("t5", base, 8'h01);
    chk("t5_locked", {31'd0, locked}, 32'd1);

`ifdef SYNC_INVERT_EN
    // 6: inverted sync and payload
    rst = 1'b1;
    @(negedge clk_300M);
    rst = 1'b0;
    chk("t6_pol_rst", {31'd0, polarity_inv}, 32'd0);
    base = bytes_q.size();
    send_frame(~16'hEB90, 8'h01, 1'b1);
    @(negedge clk_300M);
    chk("t6_pol", {31'd0, polarity_inv}, 32'd1);
    chk("t6_locked", {31'd0, locked}, 32'd1);
    chk("t6_count", bytes_q.size(), base + 8);
    check_bytes("t6", base, 8'h01);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
